// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle RV32I sequencer that decodes R/I/B instructions
// into ALU controls, samples the ALU flag and issues write/branch strobes.
module alu_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  input  logic [31:0] instr_i,
  output logic        instr_ready_o,
  output logic [4:0]  alu_op_o,
  output logic        alu_b_imm_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  input  logic        alu_flag_i,
  output logic [4:0]  rd_o,
  output logic        rd_we_o,
  output logic        br_valid_o,
  output logic        br_taken_o,
  output logic        illegal_o
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_DONE, S_TRAP} state_t;

  state_t      r_state;
  logic        r_ready;
  logic [4:0]  r_op;
  logic        r_b_imm;
  logic [31:0] r_imm;
  logic [4:0]  r_rs1;
  logic [4:0]  r_rs2;
  logic [4:0]  r_rd;
  logic        r_rd_we;
  logic        r_br_valid;
  logic        r_br_taken;
  logic        r_illegal_pulse;
  logic        r_is_branch;
  logic        r_illegal;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_legal;
  logic        w_branch;
  logic [4:0]  w_op;
  logic        w_b_imm;
  logic [31:0] w_imm;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;

  assign w_opcode = instr_i[6:0];
  assign w_f3     = instr_i[14:12];
  assign w_f7     = instr_i[31:25];

  // Combinational decode of the word offered on instr_i
  always_comb begin
    w_legal  = 1'b0;
    w_branch = 1'b0;
    w_op     = 5'd0;
    w_b_imm  = 1'b0;
    w_imm    = 32'd0;
    w_rs2    = instr_i[24:20];
    w_rd     = instr_i[11:7];
    case (w_opcode)
      OPC_R: begin
        w_op    = {1'b0, w_f7[5], w_f3};
        w_legal = (w_f7 == 7'd0) ||
                  ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      OPC_I: begin
        w_b_imm = 1'b1;
        w_rs2   = 5'd0;
        case (w_f3)
          3'b001: begin
            w_op    = {2'b00, w_f3};
            w_imm   = {27'd0, instr_i[24:20]};
            w_legal = (w_f7 == 7'd0);
          end
          3'b101: begin
            w_op    = {1'b0, w_f7[5], 3'b101};
            w_imm   = {27'd0, instr_i[24:20]};
            w_legal = (w_f7 == 7'd0) || (w_f7 == F7_ALT);
          end
          default: begin
            w_op    = {2'b00, w_f3};
            w_imm   = {{20{instr_i[31]}}, instr_i[31:20]};
            w_legal = 1'b1;
          end
        endcase
      end
      OPC_B: begin
        w_branch = 1'b1;
        w_rd     = 5'd0;
        w_op     = {2'b11, w_f3};
        w_imm    = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                    instr_i[30:25], instr_i[11:8], 1'b0};
        w_legal  = (w_f3 != 3'b010) && (w_f3 != 3'b011);
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Sequencer state and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_ready         <= 1'b0;
      r_op            <= 5'd0;
      r_b_imm         <= 1'b0;
      r_imm           <= 32'd0;
      r_rs1           <= 5'd0;
      r_rs2           <= 5'd0;
      r_rd            <= 5'd0;
      r_rd_we         <= 1'b0;
      r_br_valid      <= 1'b0;
      r_br_taken      <= 1'b0;
      r_illegal_pulse <= 1'b0;
      r_is_branch     <= 1'b0;
      r_illegal       <= 1'b0;
    end else begin
      r_rd_we         <= 1'b0;
      r_br_valid      <= 1'b0;
      r_illegal_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b1;
          if (instr_valid_i && r_ready) begin
            r_ready     <= 1'b0;
            r_state     <= S_DECODE;
            r_op        <= w_legal ? w_op : 5'd0;
            r_b_imm     <= w_legal & w_b_imm;
            r_imm       <= w_imm;
            r_rs1       <= instr_i[19:15];
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_is_branch <= w_branch;
            r_illegal   <= ~w_legal;
          end
        end
        S_DECODE: begin
          if (r_illegal) begin
            r_state         <= S_TRAP;
            r_illegal_pulse <= 1'b1;
            r_op            <= 5'd0;
            r_b_imm         <= 1'b0;
            r_imm           <= 32'd0;
            r_rs1           <= 5'd0;
            r_rs2           <= 5'd0;
            r_rd            <= 5'd0;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // ALU flag is sampled only on this edge
          r_state <= S_DONE;
          if (r_is_branch) begin
            r_br_valid <= 1'b1;
            r_br_taken <= alu_flag_i;
          end else begin
            r_rd_we <= (r_rd != 5'd0);
          end
        end
        S_DONE, S_TRAP: begin
          r_state    <= S_IDLE;
          r_ready    <= 1'b1;
          r_br_taken <= 1'b0;
          r_op       <= 5'd0;
          r_b_imm    <= 1'b0;
          r_imm      <= 32'd0;
          r_rs1      <= 5'd0;
          r_rs2      <= 5'd0;
          r_rd       <= 5'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready_o = r_ready;
  assign alu_op_o      = r_op;
  assign alu_b_imm_o   = r_b_imm;
  assign imm_o         = r_imm;
  assign rs1_o         = r_rs1;
  assign rs2_o         = r_rs2;
  assign rd_o          = r_rd;
  assign rd_we_o       = r_rd_we;
  assign br_valid_o    = r_br_valid;
  assign br_taken_o    = r_br_taken;
  assign illegal_o     = r_illegal_pulse;

endmodule
